data_sa_rd_ctrl: RTL and testbench

//  Read-side sequencer for the banked systolic-array data buffer (BAND_WIDTH banks x SRAM_DEPTH, 1 read port).
//  On a start pulse it scans a configured window: banks 0..cfg_num_bank-1, offsets base..base+len-1 per bank.

---
 rtl/data_sa_pkg.sv | 27 ++
 rtl/data_sa_skid_fifo.sv | 78 +++++++
 rtl/data_sa_rd_ctrl.sv | 139 +++++++++++++
 tb/tb_data_sa_rd_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sa_pkg.sv
// rtl/data_sa_pkg.sv - shared types and geometry for the systolic-array data buffer read path
//
// Purpose: buffer geometry constants, read-sequencer state encoding and the
// job configuration record latched on start.
// Ports: none (package).
package data_sa_pkg;

  localparam int SRAM_DEPTH = 1024;
  localparam int BAND_WIDTH = 16;
  localparam int DATA_WIDTH = 8;
  localparam int AW         = $clog2(SRAM_DEPTH);
  localparam int BW         = $clog2(BAND_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sa_rd_state_e;

  typedef struct packed {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [BW:0]   num_bank;
  } sa_rd_cfg_t;

endpackage

// File: rtl/data_sa_skid_fifo.sv
// rtl/data_sa_skid_fifo.sv - 2-entry skid FIFO with registered head output
//
// Purpose: absorbs the buffer's one-cycle read latency so the stream can
// stall without losing in-flight read data.
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   push        write push_data this cycle
//   push_data   W-bit entry (data plus last flag)
//   pop         consume the head entry this cycle
//   pop_data    head entry, driven straight from a register
//   count       number of stored entries, 0..2
module data_sa_skid_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   count_q;

  assign pop_data = head_q;
  assign count    = count_q;

  // The head register is always the oldest entry, so the output never
  // passes through a read mux; the tail only holds the second entry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_q  <= push_data;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= push_data;
          end else if (push) begin
            tail_q  <= push_data;
            count_q <= 2'd2;
          end else if (pop) begin
            count_q <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) begin
              tail_q <= push_data;
            end else begin
              count_q <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  // The issue logic upstream guarantees these never fire.
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(push && !pop && count_q == 2'd2));
      assert (!(pop && count_q == 2'd0));
    end
  end

endmodule

// File: rtl/data_sa_rd_ctrl.sv
// rtl/data_sa_rd_ctrl.sv - read sequencer from the banked SA data buffer to a valid/ready stream
//
// Purpose: on start, scans banks 0..num_bank-1 and offsets base..base+len-1
// (offset inner, wrapping inside the bank), reads the buffer and streams the
// words out with m_last on the final beat.
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   start                     launch pulse, honoured only in IDLE
//   cfg_base_addr/len/num_bank job window, latched on start
//   busy, done                job in progress / one-cycle end-of-job pulse
//   enb, addrb, dob           buffer read port (dob valid one cycle after enb)
//   m_valid/m_ready/m_data/m_last  output stream
module data_sa_rd_ctrl
  import data_sa_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [AW-1:0]         cfg_base_addr,
  input  logic [AW:0]           cfg_len,
  input  logic [BW:0]           cfg_num_bank,
  output logic                  busy,
  output logic                  done,
  output logic                  enb,
  output logic [AW+BW-1:0]      addrb,
  input  logic [DATA_WIDTH-1:0] dob,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [AW:0]   LEN_ONE  = 1;
  localparam logic [BW:0]   BANK_ONE = 1;
  localparam logic [AW-1:0] ADDR_ONE = 1;

  sa_rd_state_e    state_q;
  sa_rd_cfg_t      cfg_q;
  logic [AW:0]     off_cnt_q;
  logic [BW:0]     bank_cnt_q;
  logic [AW-1:0]   off_addr_q;
  logic            inflight_q;
  logic            inflight_last_q;

  logic [1:0]          fifo_count;
  logic [DATA_WIDTH:0] fifo_out;
  logic                pop;
  logic [2:0]          outstanding;
  logic                can_issue;
  logic                bank_end;
  logic                last_issue;

  assign m_valid = (fifo_count != 2'd0);
  assign pop     = m_valid & m_ready;
  assign {m_last, m_data} = fifo_out;

  // Reads in flight plus words already buffered must fit the two FIFO slots.
  // Issuing at two outstanding is safe only when a slot frees this cycle,
  // which is what keeps a 1 beat/cycle stream bubble-free.
  assign outstanding = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign can_issue   = (outstanding < 3'd2) || ((outstanding == 3'd2) && pop);
  assign enb         = (state_q == RUN) && can_issue;

  assign bank_end   = (off_cnt_q + LEN_ONE == cfg_q.len);
  assign last_issue = bank_end && (bank_cnt_q + BANK_ONE == cfg_q.num_bank);
  assign addrb      = {bank_cnt_q[BW-1:0], off_addr_q};

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= IDLE;
      cfg_q           <= '0;
      off_cnt_q       <= '0;
      bank_cnt_q      <= '0;
      off_addr_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      // The last flag rides with its read so it lands in the FIFO
      // alongside the matching data word.
      inflight_q      <= enb;
      inflight_last_q <= enb && last_issue;
      case (state_q)
        IDLE: begin
          if (start) begin
            cfg_q.base     <= cfg_base_addr;
            cfg_q.len      <= cfg_len;
            cfg_q.num_bank <= cfg_num_bank;
            off_cnt_q      <= '0;
            bank_cnt_q     <= '0;
            off_addr_q     <= cfg_base_addr;
            state_q        <= ((cfg_len == '0) || (cfg_num_bank == '0)) ? DONE : RUN;
          end
        end
        RUN: begin
          if (enb) begin
            if (last_issue) begin
              state_q <= DRAIN;
            end else if (bank_end) begin
              off_cnt_q  <= '0;
              bank_cnt_q <= bank_cnt_q + BANK_ONE;
              off_addr_q <= cfg_q.base;
            end else begin
              off_cnt_q  <= off_cnt_q + LEN_ONE;
              // Natural AW-bit overflow gives the wrap inside the bank.
              off_addr_q <= off_addr_q + ADDR_ONE;
            end
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  data_sa_skid_fifo #(
    .W(DATA_WIDTH + 1)
  ) u_skid_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (inflight_q),
    .push_data ({inflight_last_q, dob}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_data_sa_rd_ctrl.sv
// tb/tb_data_sa_rd_ctrl.sv - directed self-checking bench for data_sa_rd_ctrl
module tb_data_sa_rd_ctrl;
  import data_sa_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [9:0]  cfg_base_addr;
  logic [10:0] cfg_len;
  logic [4:0]  cfg_num_bank;
  logic        busy;
  logic        done;
  logic        enb;
  logic [13:0] addrb;
  logic [7:0]  dob = 8'h00;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [13:0] enb_addr[$];
  int          enb_cyc[$];
  logic [7:0]  beat_data[$];
  logic        beat_last[$];
  int          beat_cyc[$];
  int          done_cyc[$];
  int          valid_cnt;
  int          busy_cnt;
  int          hold_viol;
  int          max_outst;
  logic        hold_pend;
  logic [7:0]  hold_data;
  logic        hold_last;

  data_sa_rd_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_len       (cfg_len),
    .cfg_num_bank  (cfg_num_bank),
    .busy          (busy),
    .done          (done),
    .enb           (enb),
    .addrb         (addrb),
    .dob           (dob),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [13:0] a);
    return a[7:0] ^ {a[13:10], a[11:8]};
  endfunction

  // Buffer model: one-cycle read latency.
  always @(posedge clk) begin
    if (enb) dob <= memf(addrb);
  end

  function automatic logic [13:0] exp_addr(input int b, input int l, input int k);
    int bank;
    int off;
    bank = k / l;
    off  = (b + (k % l)) % 1024;
    return 14'(bank * 1024 + off);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    enb_addr.delete(); enb_cyc.delete();
    beat_data.delete(); beat_last.delete(); beat_cyc.delete();
    done_cyc.delete();
    valid_cnt = 0; busy_cnt = 0; hold_viol = 0; max_outst = 0;
    hold_pend = 1'b0; hold_data = 8'h00; hold_last = 1'b0;
  endtask

  task automatic tick();
    int o;
    @(negedge clk);
    o = enb_addr.size() - beat_data.size();
    if (o > max_outst) max_outst = o;
    if (enb) begin enb_addr.push_back(addrb); enb_cyc.push_back(cyc); end
    if (m_valid) valid_cnt++;
    if (busy) busy_cnt++;
    if (m_valid && m_ready) begin
      beat_data.push_back(m_data); beat_last.push_back(m_last); beat_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (hold_pend && !(m_valid && m_data == hold_data && m_last == hold_last)) hold_viol++;
    hold_pend = m_valid && !m_ready;
    hold_data = m_data;
    hold_last = m_last;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_ready(input int mode);
    case (mode)
      1:       m_ready = (cyc % 2 == 0);
      2:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = 1'b1;
    endcase
  endtask

  task automatic run_job(input int b, input int l, input int n, input int mode,
                         input int restart_at, input int budget);
    clear();
    cyc = 0;
    cfg_base_addr = 10'(b); cfg_len = 11'(l); cfg_num_bank = 5'(n);
    start = 1'b1;
    drive_ready(mode);
    tick();
    start = 1'b0;
    cfg_base_addr = ~10'(b); cfg_len = 11'd2; cfg_num_bank = 5'd3;
    while (done_cyc.size() == 0 && cyc < budget) begin
      start = (cyc == restart_at);
      drive_ready(mode);
      tick();
    end
    start = 1'b0;
    m_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic check_stream(input string t, input int b, input int l, input int n);
    int mis;
    int nl;
    int total;
    total = l * n;
    mis = 0;
    nl = 0;
    chk({t, "_enb_cnt"}, enb_addr.size(), total);
    chk({t, "_beat_cnt"}, beat_data.size(), total);
    foreach (enb_addr[i]) if (enb_addr[i] !== exp_addr(b, l, i)) mis++;
    foreach (beat_data[i]) begin
      if (beat_data[i] !== memf(exp_addr(b, l, i))) mis++;
      if (beat_last[i]) nl++;
    end
    chk({t, "_mismatch"}, mis, 0);
    chk({t, "_last_cnt"}, nl, 1);
    chk({t, "_last_pos"}, beat_last[total-1], 1);
    chk({t, "_done_cnt"}, done_cyc.size(), 1);
    chk({t, "_hold_viol"}, hold_viol, 0);
    chk({t, "_outst_le2"}, (max_outst <= 2), 1);
  endtask

  initial begin
    logic [13:0] t1_addr [8];
    int n_enb;
    int n_valid;
    t1_addr = '{14'h000, 14'h001, 14'h002, 14'h003, 14'h400, 14'h401, 14'h402, 14'h403};
    rstn = 1'b0; start = 1'b0; m_ready = 1'b0;
    cfg_base_addr = '0; cfg_len = '0; cfg_num_bank = '0;
    clear();
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_enb", enb, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    rstn = 1'b1;
    m_ready = 1'b1;
    tick();

    // 1: two banks, full-rate stream, exact cycle timing
    run_job(0, 4, 2, 0, -1, 100);
    chk("t1_enb_cnt", enb_addr.size(), 8);
    chk("t1_beat_cnt", beat_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_addr%0d", i), enb_addr[i], t1_addr[i]);
      chk($sformatf("t1_enb_cyc%0d", i), enb_cyc[i], i + 1);
      chk($sformatf("t1_beat_cyc%0d", i), beat_cyc[i], i + 3);
      chk($sformatf("t1_data%0d", i), beat_data[i], memf(t1_addr[i]));
      chk($sformatf("t1_last%0d", i), beat_last[i], (i == 7));
    end
    chk("t1_done_cnt", done_cyc.size(), 1);
    chk("t1_done_cyc", done_cyc[0], 11);
    chk("t1_busy_cycles", busy_cnt, 10);
    chk("t1_idle_busy", busy, 0);

    // 2: offset wrap inside bank 0
    run_job(10'h3FE, 4, 1, 0, -1, 100);
    chk("t2_addr0", enb_addr[0], 14'h3FE);
    chk("t2_addr1", enb_addr[1], 14'h3FF);
    chk("t2_addr2", enb_addr[2], 14'h000);
    chk("t2_addr3", enb_addr[3], 14'h001);
    check_stream("t2", 10'h3FE, 4, 1);

    // 3: alternating backpressure
    run_job(10'h010, 8, 1, 1, -1, 200);
    check_stream("t3", 10'h010, 8, 1);

    // 4: empty windows
    run_job(0, 0, 2, 0, -1, 50);
    chk("t4a_enb", enb_addr.size(), 0);
    chk("t4a_valid", valid_cnt, 0);
    chk("t4a_busy", busy_cnt, 0);
    chk("t4a_done_cnt", done_cyc.size(), 1);
    chk("t4a_done_cyc", done_cyc[0], 1);
    run_job(0, 5, 0, 0, -1, 50);
    chk("t4b_enb", enb_addr.size(), 0);
    chk("t4b_valid", valid_cnt, 0);
    chk("t4b_done_cnt", done_cyc.size(), 1);
    chk("t4b_done_cyc", done_cyc[0], 1);

    // 5: restart while busy is ignored; cfg changes while busy are ignored
    run_job(10'h020, 16, 1, 0, 5, 100);
    check_stream("t5", 10'h020, 16, 1);
    chk("t5_done_cyc", done_cyc[0], 19);
    chk("t5_last_beat_cyc", beat_cyc[15], 18);

    // 5b: reset mid-job aborts without done
    clear();
    cyc = 0;
    cfg_base_addr = 10'h000; cfg_len = 11'd16; cfg_num_bank = 5'd2;
    start = 1'b1; m_ready = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 6) tick();
    rstn = 1'b0;
    tick();
    chk("t5r_enb", enb, 0);
    chk("t5r_busy", busy, 0);
    chk("t5r_done", done, 0);
    chk("t5r_addrb", addrb, 0);
    chk("t5r_m_valid", m_valid, 0);
    chk("t5r_m_last", m_last, 0);
    chk("t5r_m_data", m_data, 0);
    rstn = 1'b1;
    n_enb = enb_addr.size();
    n_valid = valid_cnt;
    repeat (10) tick();
    chk("t5r_no_enb", enb_addr.size(), n_enb);
    chk("t5r_no_valid", valid_cnt, n_valid);
    chk("t5r_no_done", done_cyc.size(), 0);

    // 6: full buffer with random backpressure
    run_job(10'h155, 1024, 16, 2, -1, 40000);
    check_stream("t6", 10'h155, 1024, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
